port_controller: RTL and testbench
==================================

# port_controller

Single-clock I/O port decoder and interrupt source between the core88 CPU port bus and peripherals: PS/2 keyboard latch, VGA text-cursor registers, SD/SPI command interface, and a two-source interrupt requester with a periodic timer. It decodes CPU port strobes, returns read data, drives peripheral control lines and presents vectored interrupts to the CPU.

## Interface
- TIMER_DIV, 25000, clock cycles between timer ticks; 0 disables the timer.
- clock  in  1  system clock; all logic on its rising edge.
- resetn  in  1  reset; synchronous and active-low.
- port_clk  in  1  CPU port access strobe; an access occurs on its 0→1 transition sampled on clock.
- port  in  16  port address.
- port_o  in  8  write data from CPU.
- port_i  out  8  read data to CPU.
- port_w  in  1  1 = write access, 0 = read access.
- vga_cursor  out  11  text cursor linear position.
- ps2_data  in  8  current keyboard scancode.
- ps2_hit  in  1  new-scancode indication; 0→1 transition is the event.
- sd_signal  out  1  one-cycle command-issue pulse to the SD unit.
- sd_cmd  out  2  SD command code.
- sd_out  out  8  byte to send to the card.
- sd_din  in  8  byte received from the card.
- sd_busy  in  1  SD unit busy.
- sd_timeout  in  1  SD unit timeout flag.
- intr  out  1  interrupt request to CPU.
- irq  out  8  interrupt vector, valid while intr=1.
- intr_latch  in  1  CPU acknowledge; 1 while intr=1 clears the request.

## Operation
- Edge detectors: registered previous values of port_clk and ps2_hit; event = current 1 and previous 0.
- Port write (event, port_w=1), by port:
  - 0x0021: mask register; bit0 masks timer, bit1 masks keyboard (1 = masked).
  - 0x03D4: CRT index register (8 bits).
  - 0x03D5: if index=0x0E, cursor[10:8] ← port_o[2:0]; if index=0x0F, cursor[7:0] ← port_o; other indexes ignored.
  - 0xFF00: sd_out ← port_o.
  - 0xFF01: sd_cmd ← port_o[1:0]; sd_signal=1 for exactly one cycle. Issued regardless of sd_busy.
  - Other addresses: ignored.
- Port read (event, port_w=0), port_i ← by port:
  - 0x0060: keyboard data register; clears kb_ready.
  - 0x0064: {7'b0, kb_ready}.
  - 0x0021: mask register.
  - 0x03D4: index. 0x03D5: cursor byte per index (0x0E → {5'b0, cursor[10:8]}, 0x0F → cursor[7:0], else 0x00).
  - 0xFF00: sd_din. 0xFF01: {6'b0, sd_timeout, sd_busy}.
  - Other addresses: 0xFF.
- Keyboard: on ps2_hit event, kb_data ← ps2_data, kb_ready ← 1, kb_pend ← 1 (unless masked). A new hit overwrites kb_data. If a ps2_hit event and a 0x0060 read land in the same cycle, the read returns the old data and kb_ready ends at 1.
- Timer: counter counts 0..TIMER_DIV-1 and wraps; at wrap, tmr_pend ← 1 (unless masked). TIMER_DIV=0 keeps the counter at 0 and never sets tmr_pend.
- Interrupt FSM, states IDLE (intr=0) and REQ (intr=1):
  - IDLE with tmr_pend → REQ, irq=0x08, tmr_pend cleared. Timer has priority.
  - Else IDLE with kb_pend → REQ, irq=0x09, kb_pend cleared.
  - REQ with intr_latch=1 → IDLE; irq holds its last value.
  - Pending bits that set while in REQ stay set. A pending bit that sets on the same cycle it is cleared stays set (set wins).
- Reset values: port_i=0x00, vga_cursor=0, sd_signal=0, sd_cmd=0, sd_out=0x00, intr=0, irq=0x00. All internal state also resets: mask=0x00, index=0x00, kb_data=0x00, kb_ready=0, pending bits=0, timer counter=0, and both edge-detector history bits=0.

## Timing
- Access is taken on the first clock edge that sees port_clk=1 after a 0 sample. port_i is valid from the next cycle and holds until the next read. Write effects (registers, vga_cursor, sd_out, sd_cmd) are visible the next cycle.
- A held-high port_clk performs only one access.
- sd_signal rises in the cycle after the 0xFF01 write event and is high for exactly one cycle.
- intr asserts 1 cycle after a pending bit is set (from IDLE). It deasserts 1 cycle after intr_latch is sampled high. The next request can assert on the following cycle.
- Reset mid-operation clears all requests and pending bits. After reset, port_clk or ps2_hit already at 1 generate an event on the first active cycle.

## Test plan
- Cursor: write 0x0E→0x3D4, 0x07→0x3D5, 0x0F→0x3D4, 0xD0→0x3D5 -> vga_cursor=0x7D0. Readback of 0x3D5 with index 0x0F gives 0xD0.
- Keyboard: ps2_data=0x01, ps2_hit pulse (TIMER_DIV=0) -> intr=1 with irq=0x09 one cycle later. Then:
  - intr_latch pulse -> intr=0.
  - Read 0x64 -> 0x01.
  - Read 0x60 -> 0x01, followed by a read of 0x64 -> 0x00.
- SD: write 0xFF00=0xA5, then 0xFF01=0x02 -> sd_out=0xA5, sd_cmd=2, and one-cycle sd_signal. With sd_din=0x3C, sd_busy=1 and sd_timeout=0: read 0xFF00 -> 0x3C, read 0xFF01 -> 0x01.
- Priority: TIMER_DIV=8, keyboard hit on the same cycle as the timer wrap -> first irq=0x08; after acknowledge, irq=0x09.
- Masking: write 0x21=0x02, then ps2_hit -> no intr, but 0x64 reads 0x01. An unmapped read such as 0x1234 -> 0xFF.
- Reset: resetn=0 while intr=1 -> the next cycle has intr=0, vga_cursor=0, port_i=0x00 and no stale pending interrupt.

Source files
------------

// File: rtl/port_controller_if.sv
// CPU port bus between the core88 CPU and port_controller: port strobe, address,
// data in both directions, and the vectored interrupt handshake.
interface port_controller_if;
  logic        port_clk;
  logic [15:0] port;
  logic [7:0]  port_o;
  logic [7:0]  port_i;
  logic        port_w;
  logic        intr;
  logic [7:0]  irq;
  logic        intr_latch;

  modport master (
    output port_clk, port, port_o, port_w, intr_latch,
    input  port_i, intr, irq
  );

  modport slave (
    input  port_clk, port, port_o, port_w, intr_latch,
    output port_i, intr, irq
  );
endinterface

// File: rtl/port_controller.sv
// CPU port decoder: keyboard latch, VGA cursor registers, SD command interface
// and a two-source vectored interrupt requester with a periodic timer.
module port_controller #(
  parameter int unsigned TIMER_DIV = 25000
) (
  input  logic               clock,
  input  logic               resetn,
  port_controller_if.slave   bus,
  output logic [10:0]        vga_cursor,
  input  logic [7:0]         ps2_data,
  input  logic               ps2_hit,
  output logic               sd_signal,
  output logic [1:0]         sd_cmd,
  output logic [7:0]         sd_out,
  input  logic [7:0]         sd_din,
  input  logic               sd_busy,
  input  logic               sd_timeout
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic        pclk_q, hit_q;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  index_q, index_d;
  logic [10:0] cursor_q, cursor_d;
  logic [7:0]  kb_data_q, kb_data_d;
  logic        kb_ready_q, kb_ready_d;
  logic        kb_pend_q, kb_pend_d;
  logic        tmr_pend_q, tmr_pend_d;
  logic [31:0] tmr_cnt_q, tmr_cnt_d;
  logic [0:0]  state_q, state_d;
  logic [7:0]  irq_q, irq_d;
  logic [7:0]  port_i_q, port_i_d;
  logic        sd_signal_q, sd_signal_d;
  logic [1:0]  sd_cmd_q, sd_cmd_d;
  logic [7:0]  sd_out_q, sd_out_d;

  logic acc, kb_ev, tmr_wrap;

  always_comb begin
    acc         = bus.port_clk & ~pclk_q;
    kb_ev       = ps2_hit & ~hit_q;
    tmr_wrap    = (TIMER_DIV != 0) && (tmr_cnt_q == TIMER_DIV - 32'd1);
    mask_d      = mask_q;
    index_d     = index_q;
    cursor_d    = cursor_q;
    kb_data_d   = kb_data_q;
    kb_ready_d  = kb_ready_q;
    kb_pend_d   = kb_pend_q;
    tmr_pend_d  = tmr_pend_q;
    state_d     = state_q;
    irq_d       = irq_q;
    port_i_d    = port_i_q;
    sd_signal_d = 1'b0;
    sd_cmd_d    = sd_cmd_q;
    sd_out_d    = sd_out_q;
    tmr_cnt_d   = '0;

    if (acc && bus.port_w) begin
      case (bus.port)
        16'h0021: mask_d = bus.port_o;
        16'h03D4: index_d = bus.port_o;
        16'h03D5: begin
          if (index_q == 8'h0E)      cursor_d[10:8] = bus.port_o[2:0];
          else if (index_q == 8'h0F) cursor_d[7:0]  = bus.port_o;
        end
        16'hFF00: sd_out_d = bus.port_o;
        16'hFF01: begin
          sd_cmd_d    = bus.port_o[1:0];
          sd_signal_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (acc && !bus.port_w) begin
      case (bus.port)
        16'h0060: begin
          port_i_d   = kb_data_q;
          kb_ready_d = 1'b0;
        end
        16'h0064: port_i_d = {7'b0, kb_ready_q};
        16'h0021: port_i_d = mask_q;
        16'h03D4: port_i_d = index_q;
        16'h03D5: begin
          if (index_q == 8'h0E)      port_i_d = {5'b0, cursor_q[10:8]};
          else if (index_q == 8'h0F) port_i_d = cursor_q[7:0];
          else                       port_i_d = 8'h00;
        end
        16'hFF00: port_i_d = sd_din;
        16'hFF01: port_i_d = {6'b0, sd_timeout, sd_busy};
        default:  port_i_d = 8'hFF;
      endcase
    end

    // A hit placed after the 0x0060 read lets the new scancode keep kb_ready set
    if (kb_ev) begin
      kb_data_d  = ps2_data;
      kb_ready_d = 1'b1;
    end

    if (TIMER_DIV != 0 && !tmr_wrap) tmr_cnt_d = tmr_cnt_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (tmr_pend_q) begin
          state_d    = REQ;
          irq_d      = 8'h08;
          tmr_pend_d = 1'b0;
        end else if (kb_pend_q) begin
          state_d   = REQ;
          irq_d     = 8'h09;
          kb_pend_d = 1'b0;
        end
      end
      default: if (bus.intr_latch) state_d = IDLE;
    endcase

    // Sets come after the FSM clears so a same-cycle set is not lost
    if (tmr_wrap && !mask_q[0]) tmr_pend_d = 1'b1;
    if (kb_ev && !mask_q[1])    kb_pend_d  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pclk_q      <= 1'b0;
      hit_q       <= 1'b0;
      mask_q      <= '0;
      index_q     <= '0;
      cursor_q    <= '0;
      kb_data_q   <= '0;
      kb_ready_q  <= 1'b0;
      kb_pend_q   <= 1'b0;
      tmr_pend_q  <= 1'b0;
      tmr_cnt_q   <= '0;
      state_q     <= IDLE;
      irq_q       <= '0;
      port_i_q    <= '0;
      sd_signal_q <= 1'b0;
      sd_cmd_q    <= '0;
      sd_out_q    <= '0;
    end else begin
      pclk_q      <= bus.port_clk;
      hit_q       <= ps2_hit;
      mask_q      <= mask_d;
      index_q     <= index_d;
      cursor_q    <= cursor_d;
      kb_data_q   <= kb_data_d;
      kb_ready_q  <= kb_ready_d;
      kb_pend_q   <= kb_pend_d;
      tmr_pend_q  <= tmr_pend_d;
      tmr_cnt_q   <= tmr_cnt_d;
      state_q     <= state_d;
      irq_q       <= irq_d;
      port_i_q    <= port_i_d;
      sd_signal_q <= sd_signal_d;
      sd_cmd_q    <= sd_cmd_d;
      sd_out_q    <= sd_out_d;
    end
  end

  assign bus.port_i  = port_i_q;
  assign bus.intr    = (state_q == REQ);
  assign bus.irq     = irq_q;
  assign vga_cursor  = cursor_q;
  assign sd_signal   = sd_signal_q;
  assign sd_cmd      = sd_cmd_q;
  assign sd_out      = sd_out_q;
endmodule

// File: tb/tb_port_controller.sv
// Two port_controller instances (timer off, timer every 8 cycles) driven by the
// same directed and random stimulus and compared against a behavioural model.
module tb_port_controller;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn = 1'b0;
  logic        pclk = 1'b0, pw = 1'b0, latch = 1'b0;
  logic [15:0] paddr = '0;
  logic [7:0]  pdata = '0;
  logic [7:0]  ps2_data = '0, sd_din = '0;
  logic        ps2_hit = 1'b0, sd_busy = 1'b0, sd_timeout = 1'b0;

  port_controller_if bus0();
  port_controller_if bus1();
  assign bus0.port_clk = pclk;  assign bus1.port_clk = pclk;
  assign bus0.port = paddr;     assign bus1.port = paddr;
  assign bus0.port_o = pdata;   assign bus1.port_o = pdata;
  assign bus0.port_w = pw;      assign bus1.port_w = pw;
  assign bus0.intr_latch = latch; assign bus1.intr_latch = latch;

  logic [10:0] cur0, cur1;
  logic        sig0, sig1;
  logic [1:0]  cmd0, cmd1;
  logic [7:0]  out0, out1;

  port_controller #(.TIMER_DIV(0)) dut0 (
    .clock(clock), .resetn(resetn), .bus(bus0.slave), .vga_cursor(cur0),
    .ps2_data(ps2_data), .ps2_hit(ps2_hit), .sd_signal(sig0), .sd_cmd(cmd0),
    .sd_out(out0), .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout));
  port_controller #(.TIMER_DIV(8)) dut1 (
    .clock(clock), .resetn(resetn), .bus(bus1.slave), .vga_cursor(cur1),
    .ps2_data(ps2_data), .ps2_hit(ps2_hit), .sd_signal(sig1), .sd_cmd(cmd1),
    .sd_out(out1), .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout));

  logic [7:0]  a_pi[2], a_irq[2], a_out[2];
  logic        a_intr[2], a_sig[2];
  logic [10:0] a_cur[2];
  logic [1:0]  a_cmd[2];
  assign a_pi[0] = bus0.port_i;  assign a_pi[1] = bus1.port_i;
  assign a_irq[0] = bus0.irq;    assign a_irq[1] = bus1.irq;
  assign a_intr[0] = bus0.intr;  assign a_intr[1] = bus1.intr;
  assign a_cur[0] = cur0;        assign a_cur[1] = cur1;
  assign a_sig[0] = sig0;        assign a_sig[1] = sig1;
  assign a_cmd[0] = cmd0;        assign a_cmd[1] = cmd1;
  assign a_out[0] = out0;        assign a_out[1] = out1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned DIVS[2] = '{0, 8};
  logic        m_started = 1'b0;
  logic        m_pp[2], m_hp[2], m_intr[2], m_tp[2], m_kp[2], m_kr[2], m_sig[2];
  logic [7:0]  m_mask[2], m_idx[2], m_kd[2], m_pi[2], m_irq[2], m_sdout[2];
  logic [1:0]  m_cmd[2];
  int unsigned m_cur[2], m_cnt[2];

  function automatic logic [7:0] read_value(input int k, input logic [15:0] a);
    case (a)
      16'h0060: return m_kd[k];
      16'h0064: return m_kr[k] ? 8'h01 : 8'h00;
      16'h0021: return m_mask[k];
      16'h03D4: return m_idx[k];
      16'h03D5: return (m_idx[k] == 8'h0E) ? 8'(m_cur[k] / 256) :
                       (m_idx[k] == 8'h0F) ? 8'(m_cur[k] % 256) : 8'h00;
      16'hFF00: return sd_din;
      16'hFF01: return 8'(2 * int'(sd_timeout) + int'(sd_busy));
      default:  return 8'hFF;
    endcase
  endfunction

  task automatic model_step(input int k);
    logic acc, kev, wrap;
    if (!resetn) begin
      m_pp[k] = 0; m_hp[k] = 0; m_intr[k] = 0; m_tp[k] = 0; m_kp[k] = 0;
      m_kr[k] = 0; m_sig[k] = 0; m_mask[k] = 0; m_idx[k] = 0; m_kd[k] = 0;
      m_pi[k] = 0; m_irq[k] = 0; m_sdout[k] = 0; m_cmd[k] = 0;
      m_cur[k] = 0; m_cnt[k] = 0;
      m_started = 1'b1;
      return;
    end
    acc = pclk && !m_pp[k];
    kev = ps2_hit && !m_hp[k];
    m_pp[k] = pclk;
    m_hp[k] = ps2_hit;
    wrap = (DIVS[k] != 0) && (m_cnt[k] == DIVS[k] - 1);
    m_cnt[k] = (DIVS[k] == 0 || wrap) ? 0 : m_cnt[k] + 1;
    m_sig[k] = 0;
    if (m_intr[k]) begin
      if (latch) m_intr[k] = 0;
    end else if (m_tp[k]) begin
      m_intr[k] = 1; m_irq[k] = 8'h08; m_tp[k] = 0;
    end else if (m_kp[k]) begin
      m_intr[k] = 1; m_irq[k] = 8'h09; m_kp[k] = 0;
    end
    if (wrap && !m_mask[k][0]) m_tp[k] = 1;
    if (kev && !m_mask[k][1]) m_kp[k] = 1;
    if (acc && !pw) begin
      m_pi[k] = read_value(k, paddr);
      if (paddr == 16'h0060) m_kr[k] = 0;
    end
    if (kev) begin m_kd[k] = ps2_data; m_kr[k] = 1; end
    if (acc && pw) begin
      case (paddr)
        16'h0021: m_mask[k] = pdata;
        16'h03D4: m_idx[k] = pdata;
        16'h03D5: begin
          if (m_idx[k] == 8'h0E) m_cur[k] = m_cur[k] % 256 + (pdata % 8) * 256;
          else if (m_idx[k] == 8'h0F) m_cur[k] = (m_cur[k] / 256) * 256 + pdata;
        end
        16'hFF00: m_sdout[k] = pdata;
        16'hFF01: begin m_cmd[k] = pdata[1:0]; m_sig[k] = 1; end
        default: ;
      endcase
    end
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
  end

  always @(posedge clock) begin
    #1;
    if (m_started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("intr[%0d]", k), 16'(a_intr[k]), 16'(m_intr[k]));
        check($sformatf("irq[%0d]", k), 16'(a_irq[k]), 16'(m_irq[k]));
        check($sformatf("port_i[%0d]", k), 16'(a_pi[k]), 16'(m_pi[k]));
        check($sformatf("vga_cursor[%0d]", k), 16'(a_cur[k]), 16'(m_cur[k]));
        check($sformatf("sd_signal[%0d]", k), 16'(a_sig[k]), 16'(m_sig[k]));
        check($sformatf("sd_cmd[%0d]", k), 16'(a_cmd[k]), 16'(m_cmd[k]));
        check($sformatf("sd_out[%0d]", k), 16'(a_out[k]), 16'(m_sdout[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    paddr = a; pdata = d; pw = 1'b1; pclk = 1'b1;
    @(negedge clock);
    pclk = 1'b0;
    @(negedge clock);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v0, output logic [7:0] v1);
    paddr = a; pw = 1'b0; pclk = 1'b1;
    @(negedge clock);
    v0 = a_pi[0]; v1 = a_pi[1];
    pclk = 1'b0;
    @(negedge clock);
  endtask

  task automatic ack();
    latch = 1'b1;
    @(negedge clock);
    latch = 1'b0;
  endtask

  logic [15:0] addrs[9] = '{16'h0021, 16'h03D4, 16'h03D5, 16'hFF00, 16'hFF01,
                            16'h0060, 16'h0064, 16'h1234, 16'h0000};

  initial begin
    logic [7:0] v0, v1;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    check("reset intr", 16'(a_intr[0]), 16'h0);
    check("reset port_i", 16'(a_pi[0]), 16'h0);
    check("reset cursor", 16'(cur0), 16'h0);
    check("reset irq", 16'(a_irq[0]), 16'h0);

    // cursor
    wr(16'h03D4, 8'h0E); wr(16'h03D5, 8'h07);
    wr(16'h03D4, 8'h0F); wr(16'h03D5, 8'hD0);
    check("cursor", 16'(cur0), 16'h07D0);
    rd(16'h03D5, v0, v1);
    check("cursor readback", 16'(v0), 16'h00D0);

    // keyboard, timer-less instance
    ps2_data = 8'h01; ps2_hit = 1'b1;
    @(negedge clock);
    ps2_hit = 1'b0;
    check("kb intr not yet", 16'(a_intr[0]), 16'h0);
    @(negedge clock);
    check("kb intr", 16'(a_intr[0]), 16'h1);
    check("kb irq", 16'(a_irq[0]), 16'h09);
    ack();
    check("kb ack", 16'(a_intr[0]), 16'h0);
    rd(16'h0064, v0, v1); check("kb status", 16'(v0), 16'h01);
    rd(16'h0060, v0, v1); check("kb data", 16'(v0), 16'h01);
    rd(16'h0064, v0, v1); check("kb status cleared", 16'(v0), 16'h00);

    // SD, with port_clk held high over several edges
    wr(16'hFF00, 8'hA5);
    paddr = 16'hFF01; pdata = 8'h02; pw = 1'b1; pclk = 1'b1;
    @(negedge clock);
    check("sd_signal", 16'(sig0), 16'h1);
    check("sd_cmd", 16'(cmd0), 16'h2);
    check("sd_out", 16'(out0), 16'hA5);
    @(negedge clock);
    check("sd_signal one cycle", 16'(sig0), 16'h0);
    @(negedge clock);
    check("held strobe single access", 16'(sig0), 16'h0);
    pclk = 1'b0;
    @(negedge clock);
    sd_din = 8'h3C; sd_busy = 1'b1; sd_timeout = 1'b0;
    rd(16'hFF00, v0, v1); check("sd_din read", 16'(v0), 16'h3C);
    rd(16'hFF01, v0, v1); check("sd status read", 16'(v0), 16'h01);

    // masking and unmapped read
    wr(16'h0021, 8'h02);
    ps2_data = 8'h55; ps2_hit = 1'b1;
    @(negedge clock);
    ps2_hit = 1'b0;
    repeat (3) @(negedge clock);
    check("masked kb no intr", 16'(a_intr[0]), 16'h0);
    rd(16'h0064, v0, v1); check("masked kb status", 16'(v0), 16'h01);
    rd(16'h0021, v0, v1); check("mask readback", 16'(v0), 16'h02);
    rd(16'h1234, v0, v1); check("unmapped read", 16'(v0), 16'hFF);
    wr(16'h0021, 8'h00);

    // priority: keyboard hit on the timer wrap edge of the TIMER_DIV=8 instance
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 20 && m_cnt[1] != 7; i++) @(negedge clock);
    check("timer sync bound", 16'(m_cnt[1]), 16'd7);
    ps2_data = 8'h77; ps2_hit = 1'b1;
    @(negedge clock);
    ps2_hit = 1'b0;
    @(negedge clock);
    check("prio first intr", 16'(a_intr[1]), 16'h1);
    check("prio first irq", 16'(a_irq[1]), 16'h08);
    ack();
    check("prio ack", 16'(a_intr[1]), 16'h0);
    @(negedge clock);
    check("prio second intr", 16'(a_intr[1]), 16'h1);
    check("prio second irq", 16'(a_irq[1]), 16'h09);
    ack();
    @(negedge clock);

    // reset while requesting
    wr(16'h03D4, 8'h0F); wr(16'h03D5, 8'h33);
    rd(16'h1234, v0, v1);
    ps2_hit = 1'b1;
    @(negedge clock);
    ps2_hit = 1'b0;
    @(negedge clock);
    check("pre-reset intr", 16'(a_intr[0]), 16'h1);
    resetn = 1'b0;
    @(negedge clock);
    check("mid reset intr", 16'(a_intr[0]), 16'h0);
    check("mid reset cursor", 16'(cur0), 16'h0);
    check("mid reset port_i", 16'(a_pi[0]), 16'h0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("no stale pending", 16'(a_intr[0]), 16'h0);

    // ps2_hit already high when reset releases
    resetn = 1'b0; ps2_hit = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("post-reset hit pending", 16'(a_intr[0]), 16'h0);
    @(negedge clock);
    check("post-reset hit intr", 16'(a_intr[0]), 16'h1);
    ps2_hit = 1'b0;
    ack();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int sel;
      sel = int'($urandom_range(0, 8));
      paddr = (sel == 8) ? 16'($urandom) : addrs[sel];
      pdata = 8'($urandom);
      if (paddr == 16'h03D4 && $urandom_range(0, 3) != 0)
        pdata = ($urandom_range(0, 1) != 0) ? 8'h0E : 8'h0F;
      if (paddr == 16'h0021) pdata = 8'($urandom_range(0, 3));
      pw = 1'($urandom_range(0, 1));
      pclk = 1'($urandom_range(0, 1));
      ps2_hit = ($urandom_range(0, 3) == 0);
      ps2_data = 8'($urandom);
      latch = ($urandom_range(0, 3) == 0);
      sd_din = 8'($urandom);
      sd_busy = 1'($urandom_range(0, 1));
      sd_timeout = 1'($urandom_range(0, 1));
      resetn = ($urandom_range(0, 299) != 0);
      @(negedge clock);
    end
    resetn = 1'b1; pclk = 1'b0; ps2_hit = 1'b0; latch = 1'b0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
